// File: rtl/aux_period_meter.sv
// Measures period and high time of an asynchronous periodic input in clk cycles,
// with a per-cycle update strobe and a no-edge timeout flag.
module aux_period_meter #(
  parameter int CntMax = 100_000_000,
  localparam int CntBit = $clog2(CntMax + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              sig_in,
  output logic [CntBit-1:0] period,
  output logic [CntBit-1:0] high_time,
  output logic              valid,
  output logic              timeout
);

  localparam logic [CntBit-1:0] CntZero = {CntBit{1'b0}};
  localparam logic [CntBit-1:0] CntOne  = CntBit'(1);
  localparam logic [CntBit-1:0] CntLast = CntBit'(CntMax - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEAS = 2'd1,
    TOUT = 2'd2
  } state_t;

  state_t            state_r;
  logic              s1_r;
  logic              s2_r;
  logic              s3_r;
  logic [CntBit-1:0] cnt_r;
  logic [CntBit-1:0] hlat_r;

  logic              rise_s;
  logic              fall_s;
  logic              at_max_s;
  logic [CntBit-1:0] cnt_inc_s;

  assign rise_s    = s2_r & ~s3_r;
  assign fall_s    = ~s2_r & s3_r;
  assign at_max_s  = (cnt_r == CntLast);
  assign cnt_inc_s = cnt_r + CntOne;

  // Two-flop synchronizer plus history flop; runs independently of en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
      s3_r <= 1'b0;
    end else begin
      s1_r <= sig_in;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  // Measurement FSM with counter and registered results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= CntZero;
      hlat_r    <= CntZero;
      period    <= CntZero;
      high_time <= CntZero;
      valid     <= 1'b0;
      timeout   <= 1'b0;
    end else if (!en) begin
      state_r <= IDLE;
      cnt_r   <= CntZero;
      valid   <= 1'b0;
      timeout <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state_r)
        IDLE: begin
          if (rise_s) begin
            state_r <= MEAS;
            cnt_r   <= CntZero;
          end else if (at_max_s) begin
            state_r <= TOUT;
            timeout <= 1'b1;
          end else begin
            cnt_r <= cnt_inc_s;
          end
        end
        MEAS: begin
          if (fall_s) begin
            hlat_r <= cnt_inc_s;
          end
          // A rise on the last counted cycle still yields a valid period of CntMax.
          if (rise_s) begin
            period    <= cnt_inc_s;
            high_time <= hlat_r;
            valid     <= 1'b1;
            cnt_r     <= CntZero;
          end else if (at_max_s) begin
            state_r <= TOUT;
            timeout <= 1'b1;
          end else begin
            cnt_r <= cnt_inc_s;
          end
        end
        TOUT: begin
          if (rise_s) begin
            state_r <= MEAS;
            cnt_r   <= CntZero;
            timeout <= 1'b0;
          end else begin
            cnt_r <= CntLast;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= CntZero;
          timeout <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aux_period_meter.sv
// Scoreboard bench for aux_period_meter: expected period/high_time pushed on each
// driven rising edge, popped and compared when valid is observed.
module tb_aux_period_meter;

  localparam int CntMax = 64;
  localparam int CntBit = $clog2(CntMax + 1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              en = 1'b0;
  logic              sig_in = 1'b0;
  logic [CntBit-1:0] period;
  logic [CntBit-1:0] high_time;
  logic              valid;
  logic              timeout;

  typedef struct {
    int p;
    int h;
    int c;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   rise_cyc = 0;
  int   tout_events = 0;
  int   last_tout_cyc = 0;
  logic prev_valid = 1'b0;
  logic prev_tout = 1'b0;

  aux_period_meter #(.CntMax(CntMax)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in),
    .period(period), .high_time(high_time), .valid(valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid) begin
        checks++;
        if (prev_valid) begin
          failures++;
          $display("FAIL valid_spacing: valid high on consecutive cycles at cyc %0d", cyc);
        end
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_valid: cyc=%0d period=%0d high_time=%0d, none expected", cyc, period, high_time);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (period !== CntBit'(e.p) || high_time !== CntBit'(e.h) || cyc != e.c) begin
            failures++;
            $display("FAIL measurement: got period=%0d high_time=%0d cyc=%0d, expected period=%0d high_time=%0d cyc=%0d",
                     period, high_time, cyc, e.p, e.h, e.c);
          end
        end
      end
      if (timeout && !prev_tout) begin
        tout_events++;
        last_tout_cyc = cyc;
      end
      prev_valid = valid;
      prev_tout  = timeout;
    end else begin
      prev_valid = 1'b0;
      prev_tout  = 1'b0;
    end
  end

  task automatic drive(input logic v);
    @(posedge clk);
    #1;
    sig_in = v;
  endtask

  // One waveform cycle: rise, h-1 more high cycles, l low cycles.
  task automatic pulse(input int h, input int l, input bit push, input int ep, input int eh);
    drive(1'b1);
    rise_cyc = cyc;
    if (push) q.push_back('{ep, eh, cyc + 3});
    for (int i = 1; i < h; i++) drive(1'b1);
    for (int i = 0; i < l; i++) drive(1'b0);
  endtask

  task automatic restart();
    @(posedge clk);
    #1;
    en = 1'b0;
    sig_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    en = 1'b1;
  endtask

  task automatic drain(input string name);
    repeat (6) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: %0d expected updates never arrived, required 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    checks += 4;
    if (period !== '0)    begin failures++; $display("FAIL reset_period: got %0d want 0", period); end
    if (high_time !== '0) begin failures++; $display("FAIL reset_high_time: got %0d want 0", high_time); end
    if (valid !== 1'b0)   begin failures++; $display("FAIL reset_valid: got %b want 0", valid); end
    if (timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout: got %b want 0", timeout); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_square();
    restart();
    pulse(10, 15, 1'b0, 0, 0);
    for (int i = 0; i < 4; i++) pulse(10, 15, 1'b1, 25, 10);
    drain("square");
    checks++;
    if (timeout !== 1'b0) begin failures++; $display("FAIL square_timeout: got %b want 0", timeout); end
  endtask

  task automatic test_timeout();
    int rc;
    int t0;
    restart();
    pulse(10, 15, 1'b0, 0, 0);
    t0 = tout_events;
    pulse(10, 80, 1'b1, 25, 10);
    rc = rise_cyc;
    checks += 4;
    if (tout_events != t0 + 1 || last_tout_cyc != rc + 3 + CntMax) begin
      failures++;
      $display("FAIL timeout_assert: events=%0d at cyc %0d, required events=%0d at cyc %0d",
               tout_events - t0, last_tout_cyc, 1, rc + 3 + CntMax);
    end
    if (timeout !== 1'b1) begin failures++; $display("FAIL timeout_level: got %b want 1", timeout); end
    if (period !== CntBit'(25)) begin failures++; $display("FAIL timeout_period_hold: got %0d want 25", period); end
    if (high_time !== CntBit'(10)) begin failures++; $display("FAIL timeout_high_hold: got %0d want 10", high_time); end
    pulse(4, 4, 1'b0, 0, 0);
    checks++;
    if (timeout !== 1'b0) begin failures++; $display("FAIL timeout_clear: got %b want 0", timeout); end
    pulse(1, 1, 1'b1, 8, 4);
    drain("timeout");
  endtask

  task automatic test_boundary();
    int rc;
    int t0;
    restart();
    t0 = tout_events;
    pulse(20, 44, 1'b0, 0, 0);
    pulse(20, 45, 1'b1, 64, 20);
    rc = rise_cyc;
    checks++;
    if (tout_events != t0) begin
      failures++;
      $display("FAIL boundary_64_no_timeout: timeout events=%0d want 0", tout_events - t0);
    end
    pulse(10, 20, 1'b0, 0, 0);
    checks++;
    if (tout_events != t0 + 1 || last_tout_cyc != rc + 3 + CntMax) begin
      failures++;
      $display("FAIL boundary_65_timeout: events=%0d at cyc %0d, required 1 at cyc %0d",
               tout_events - t0, last_tout_cyc, rc + 3 + CntMax);
    end
    pulse(1, 5, 1'b1, 30, 10);
    drain("boundary");
    checks++;
    if (timeout !== 1'b0) begin failures++; $display("FAIL boundary_recover: timeout=%b want 0", timeout); end
  endtask

  task automatic test_alternate();
    restart();
    pulse(1, 1, 1'b0, 0, 0);
    for (int i = 0; i < 10; i++) pulse(1, 1, 1'b1, 2, 1);
    drain("alternate");
  endtask

  task automatic test_enable();
    restart();
    pulse(10, 15, 1'b0, 0, 0);
    pulse(10, 70, 1'b1, 25, 10);
    @(posedge clk);
    #1 en = 1'b0;
    repeat (2) @(negedge clk);
    checks += 4;
    if (timeout !== 1'b0) begin failures++; $display("FAIL en_timeout_clear: got %b want 0", timeout); end
    if (valid !== 1'b0) begin failures++; $display("FAIL en_valid: got %b want 0", valid); end
    if (period !== CntBit'(25)) begin failures++; $display("FAIL en_period_hold: got %0d want 25", period); end
    if (high_time !== CntBit'(10)) begin failures++; $display("FAIL en_high_hold: got %0d want 10", high_time); end
    repeat (3) @(posedge clk);
    #1 en = 1'b1;
    pulse(3, 4, 1'b0, 0, 0);
    pulse(2, 2, 1'b1, 7, 3);
    pulse(1, 3, 1'b1, 4, 2);
    drain("enable");
  endtask

  task automatic test_reset_mid();
    restart();
    pulse(10, 15, 1'b0, 0, 0);
    pulse(10, 15, 1'b1, 25, 10);
    for (int i = 0; i < 4; i++) drive(1'b1);
    #2;
    rst_n = 1'b0;
    sig_in = 1'b0;
    #1;
    checks += 4;
    if (period !== '0)    begin failures++; $display("FAIL rstmid_period: got %0d want 0", period); end
    if (high_time !== '0) begin failures++; $display("FAIL rstmid_high_time: got %0d want 0", high_time); end
    if (valid !== 1'b0)   begin failures++; $display("FAIL rstmid_valid: got %b want 0", valid); end
    if (timeout !== 1'b0) begin failures++; $display("FAIL rstmid_timeout: got %b want 0", timeout); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulse(6, 6, 1'b0, 0, 0);
    pulse(1, 3, 1'b1, 12, 6);
    drain("reset_mid");
  endtask

  initial begin
    test_reset();
    test_square();
    test_timeout();
    test_boundary();
    test_alternate();
    test_enable();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
